// File: rtl/exe_mt_muldiv.sv
// Multithreaded execute stage: thread-checked MEM/WB forwarding, load-use bubble,
// single-cycle ALU and an iterative shift-add MUL / restoring DIVU unit that stalls upstream.
module exe_mt_muldiv #(
  parameter int W    = 32,
  parameter int NTRD = 8,
  localparam int TW  = (NTRD > 1) ? $clog2(NTRD) : 1,
  localparam int CW  = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [TW-1:0] in_trd,
  input  logic [2:0]    in_op,
  input  logic [4:0]    in_rs_a,
  input  logic [4:0]    in_rs_b,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [4:0]    in_rd,
  input  logic          in_wr_en,
  input  logic          in_load,
  input  logic          flush,
  input  logic          hold,
  input  logic [TW-1:0] wb_trd,
  input  logic [4:0]    wb_rd,
  input  logic [W-1:0]  wb_data,
  input  logic          wb_wr_en,
  output logic          out_valid,
  output logic [TW-1:0] out_trd,
  output logic [4:0]    out_rd,
  output logic          out_wr_en,
  output logic          out_load,
  output logic [W-1:0]  out_data,
  output logic          out_ovf,
  output logic          stall_ex
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e state_q, state_d;

  logic          outValid_q, outValid_d;
  logic [TW-1:0] outTrd_q, outTrd_d;
  logic [4:0]    outRd_q, outRd_d;
  logic          outWrEn_q, outWrEn_d;
  logic          outLoad_q, outLoad_d;
  logic [W-1:0]  outData_q, outData_d;
  logic          outOvf_q, outOvf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  opA_q, opA_d;
  logic [W-1:0]  opB_q, opB_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          isDiv_q, isDiv_d;
  logic [TW-1:0] mdTrd_q, mdTrd_d;
  logic [4:0]    mdRd_q, mdRd_d;
  logic          mdWrEn_q, mdWrEn_d;

  logic          memHitA, memHitB, wbHitA, wbHitB, loadUse, isMulDiv;
  logic [W-1:0]  fwdA, fwdB, aluRes, mulSum, quoNext;
  logic          aluOvf, divGe;
  logic [W:0]    remSh, remDiff;

  // A MEM hit always wins over WB; register 0 never forwards and threads never mix.
  assign memHitA = (in_rs_a != 5'd0) && outValid_q && outWrEn_q && (outTrd_q == in_trd) && (outRd_q == in_rs_a);
  assign memHitB = (in_rs_b != 5'd0) && outValid_q && outWrEn_q && (outTrd_q == in_trd) && (outRd_q == in_rs_b);
  assign wbHitA  = (in_rs_a != 5'd0) && wb_wr_en && (wb_trd == in_trd) && (wb_rd == in_rs_a);
  assign wbHitB  = (in_rs_b != 5'd0) && wb_wr_en && (wb_trd == in_trd) && (wb_rd == in_rs_b);
  assign fwdA    = memHitA ? outData_q : (wbHitA ? wb_data : in_a);
  assign fwdB    = memHitB ? outData_q : (wbHitB ? wb_data : in_b);
  assign loadUse  = in_valid && outLoad_q && (memHitA || memHitB);
  assign isMulDiv = (in_op[2:1] == 2'b11);

  always_comb begin
    aluRes = '0;
    aluOvf = 1'b0;
    case (in_op)
      3'd0: begin
        aluRes = fwdA + fwdB;
        aluOvf = (fwdA[W-1] == fwdB[W-1]) && (aluRes[W-1] != fwdA[W-1]);
      end
      3'd1: begin
        aluRes = fwdA - fwdB;
        aluOvf = (fwdA[W-1] != fwdB[W-1]) && (aluRes[W-1] != fwdA[W-1]);
      end
      3'd2: aluRes = fwdA & fwdB;
      3'd3: aluRes = fwdA | fwdB;
      3'd4: aluRes = fwdA ^ fwdB;
      3'd5: aluRes = {{(W-1){1'b0}}, ($signed(fwdA) < $signed(fwdB))};
      default: aluRes = '0;
    endcase
  end

  // One iteration step; for DIVU opA holds the dividend shifting into the quotient.
  assign mulSum  = acc_q + (opB_q[0] ? opA_q : '0);
  assign remSh   = {acc_q, opA_q[W-1]};
  assign remDiff = remSh - {1'b0, opB_q};
  assign divGe   = ~remDiff[W];
  assign quoNext = {opA_q[W-2:0], divGe};

  always_ff @(posedge clk) begin
    if (rst)        state_q <= IDLE;
    else if (flush) state_q <= IDLE;
    else if (!hold) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid && isMulDiv && !loadUse) state_d = BUSY;
      BUSY: if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_ex = 1'b0;
    case (state_q)
      IDLE:    stall_ex = in_valid && (loadUse || isMulDiv);
      BUSY:    stall_ex = (cnt_q != '0);
      default: stall_ex = 1'b0;
    endcase
  end

  always_comb begin
    outValid_d = outValid_q;
    outTrd_d   = outTrd_q;
    outRd_d    = outRd_q;
    outWrEn_d  = outWrEn_q;
    outLoad_d  = outLoad_q;
    outData_d  = outData_q;
    outOvf_d   = outOvf_q;
    cnt_d      = cnt_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    acc_d      = acc_q;
    isDiv_d    = isDiv_q;
    mdTrd_d    = mdTrd_q;
    mdRd_d     = mdRd_q;
    mdWrEn_d   = mdWrEn_q;
    case (state_q)
      IDLE: begin
        outValid_d = 1'b0;
        if (in_valid && !loadUse) begin
          if (isMulDiv) begin
            opA_d    = fwdA;
            opB_d    = fwdB;
            acc_d    = '0;
            isDiv_d  = in_op[0];
            mdTrd_d  = in_trd;
            mdRd_d   = in_rd;
            mdWrEn_d = in_wr_en;
            cnt_d    = CW'(W - 1);
          end else begin
            outValid_d = 1'b1;
            outTrd_d   = in_trd;
            outRd_d    = in_rd;
            outWrEn_d  = in_wr_en;
            outLoad_d  = in_load;
            outData_d  = aluRes;
            outOvf_d   = aluOvf;
          end
        end
      end
      BUSY: begin
        if (isDiv_q) begin
          acc_d = divGe ? remDiff[W-1:0] : remSh[W-1:0];
          opA_d = quoNext;
        end else begin
          acc_d = mulSum;
          opA_d = opA_q << 1;
          opB_d = opB_q >> 1;
        end
        outValid_d = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          outValid_d = 1'b1;
          outTrd_d   = mdTrd_q;
          outRd_d    = mdRd_q;
          outWrEn_d  = mdWrEn_q;
          outLoad_d  = 1'b0;
          outData_d  = isDiv_q ? quoNext : mulSum;
          outOvf_d   = isDiv_q && (opB_q == '0);
        end
      end
      default: outValid_d = 1'b0;
    endcase
  end

  // Reset beats flush, flush beats hold; hold freezes everything including the iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outTrd_q   <= '0;
      outRd_q    <= '0;
      outWrEn_q  <= 1'b0;
      outLoad_q  <= 1'b0;
      outData_q  <= '0;
      outOvf_q   <= 1'b0;
      cnt_q      <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      acc_q      <= '0;
      isDiv_q    <= 1'b0;
      mdTrd_q    <= '0;
      mdRd_q     <= '0;
      mdWrEn_q   <= 1'b0;
    end else if (flush) begin
      outValid_q <= 1'b0;
      cnt_q      <= '0;
    end else if (!hold) begin
      outValid_q <= outValid_d;
      outTrd_q   <= outTrd_d;
      outRd_q    <= outRd_d;
      outWrEn_q  <= outWrEn_d;
      outLoad_q  <= outLoad_d;
      outData_q  <= outData_d;
      outOvf_q   <= outOvf_d;
      cnt_q      <= cnt_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      acc_q      <= acc_d;
      isDiv_q    <= isDiv_d;
      mdTrd_q    <= mdTrd_d;
      mdRd_q     <= mdRd_d;
      mdWrEn_q   <= mdWrEn_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_trd   = outTrd_q;
  assign out_rd    = outRd_q;
  assign out_wr_en = outWrEn_q;
  assign out_load  = outLoad_q;
  assign out_data  = outData_q;
  assign out_ovf   = outOvf_q;

endmodule

// File: tb/tb_exe_mt_muldiv.sv
// Scoreboard bench for exe_mt_muldiv: a driver issues instructions the way a stalled ID/EX would,
// predicting each EX/MEM result from plain arithmetic; a monitor pops and compares on every new out_valid.
module tb_exe_mt_muldiv;
  localparam int W    = 32;
  localparam int NTRD = 8;
  localparam int TW   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [TW-1:0] in_trd = '0;
  logic [2:0]    in_op = '0;
  logic [4:0]    in_rs_a = '0, in_rs_b = '0, in_rd = '0;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic          in_wr_en = 1'b0, in_load = 1'b0;
  logic          flush = 1'b0, hold = 1'b0;
  logic [TW-1:0] wb_trd = '0;
  logic [4:0]    wb_rd = '0;
  logic [W-1:0]  wb_data = '0;
  logic          wb_wr_en = 1'b0;
  logic          out_valid, out_wr_en, out_load, out_ovf, stall_ex;
  logic [TW-1:0] out_trd;
  logic [4:0]    out_rd;
  logic [W-1:0]  out_data;

  exe_mt_muldiv #(.W(W), .NTRD(NTRD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_trd(in_trd), .in_op(in_op),
    .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .in_wr_en(in_wr_en), .in_load(in_load), .flush(flush), .hold(hold),
    .wb_trd(wb_trd), .wb_rd(wb_rd), .wb_data(wb_data), .wb_wr_en(wb_wr_en),
    .out_valid(out_valid), .out_trd(out_trd), .out_rd(out_rd), .out_wr_en(out_wr_en),
    .out_load(out_load), .out_data(out_data), .out_ovf(out_ovf), .stall_ex(stall_ex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] trd;
    logic [4:0]    rd;
    logic          wr;
    logic          load;
    logic [W-1:0]  data;
    logic          ovf;
    longint        t;
  } exp_t;

  typedef struct {
    logic [2:0]    op;
    logic [TW-1:0] trd;
    logic [4:0]    rsA, rsB, rd;
    logic [W-1:0]  a, b;
    logic          wr, load;
  } instr_t;

  exp_t sbq[$];
  int checks = 0;
  int passes = 0;
  bit wbRandom = 1'b0;
  bit heldEdge = 1'b1;

  // Model of what the EX/MEM register should currently hold
  bit            mValid = 1'b0;
  logic [TW-1:0] mTrd = '0;
  logic [4:0]    mRd = '0;
  bit            mWr = 1'b0, mLoad = 1'b0;
  logic [W-1:0]  mData = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  function automatic instr_t mk(input logic [2:0] op, input int trd, input int rsA, input int rsB,
                                input logic [W-1:0] a, input logic [W-1:0] b, input int rd,
                                input bit wr, input bit load);
    instr_t x;
    x.op = op; x.trd = TW'(trd); x.rsA = 5'(rsA); x.rsB = 5'(rsB);
    x.a = a; x.b = b; x.rd = 5'(rd); x.wr = wr; x.load = load;
    return x;
  endfunction

  function automatic void refAlu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic ovf);
    longint sa, sb, s, lim;
    logic [2*W-1:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) << (W - 1);
    ovf = 1'b0;
    r   = '0;
    case (op)
      3'd0: begin s = sa + sb; r = s[W-1:0]; ovf = (s >= lim) || (s < -lim); end
      3'd1: begin s = sa - sb; r = s[W-1:0]; ovf = (s >= lim) || (s < -lim); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; end
      default: begin
        if (b == 0) begin r = '1; ovf = 1'b1; end
        else r = a / b;
      end
    endcase
  endfunction

  function automatic logic [W-1:0] fwd(input logic [4:0] rs, input logic [TW-1:0] trd,
                                       input logic [W-1:0] rf, output bit memHit);
    memHit = (rs != 0) && mValid && mWr && (mTrd == trd) && (mRd == rs);
    if (memHit) return mData;
    if ((rs != 0) && wb_wr_en && (wb_trd == trd) && (wb_rd == rs)) return wb_data;
    return rf;
  endfunction

  task automatic randWb();
    if (wbRandom) begin
      wb_trd   = TW'($urandom_range(0, 1));
      wb_rd    = 5'($urandom_range(0, 3));
      wb_data  = $urandom;
      wb_wr_en = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic pushExp(input logic [W-1:0] r, input logic ovf);
    exp_t e;
    mValid = 1'b1; mData = r;
    e.trd = mTrd; e.rd = mRd; e.wr = mWr; e.load = mLoad; e.data = r; e.ovf = ovf; e.t = longint'($time);
    sbq.push_back(e);
  endtask

  // Entered and left right after a negedge; holds the instruction while stall_ex says so.
  task automatic applyStimulus(input instr_t x, input int holdAtK, input int flushAtK);
    logic [W-1:0] a, b, r;
    logic ovf;
    bit hA, hB, lu, md, done, flushed;
    done = 1'b0; flushed = 1'b0;
    md = (x.op >= 3'd6);
    in_valid = 1'b1; in_op = x.op; in_trd = x.trd; in_rs_a = x.rsA; in_rs_b = x.rsB;
    in_a = x.a; in_b = x.b; in_rd = x.rd; in_wr_en = x.wr; in_load = x.load;
    while (!done) begin
      randWb();
      #1;
      a  = fwd(x.rsA, x.trd, x.a, hA);
      b  = fwd(x.rsB, x.trd, x.b, hB);
      lu = mLoad && (hA || hB);
      refAlu(x.op, a, b, r, ovf);
      checkOutput("stall_ex_issue", 64'(stall_ex), 64'(lu || md));
      @(posedge clk);
      if (lu) begin
        mValid = 1'b0;
      end else if (!md) begin
        mTrd = x.trd; mRd = x.rd; mWr = x.wr; mLoad = x.load;
        pushExp(r, ovf);
        done = 1'b1;
      end else begin
        mValid = 1'b0;
        for (int k = W - 1; k >= 0; k--) begin
          @(negedge clk);
          randWb();
          if (k == holdAtK) begin
            hold = 1'b1;
            repeat (3) begin
              #1;
              checkOutput("stall_ex_hold", 64'(stall_ex), 64'(1));
              @(posedge clk);
              @(negedge clk);
            end
            hold = 1'b0;
          end
          if (k == flushAtK) begin
            flush = 1'b1;
            #1;
            checkOutput("stall_ex_flush_cycle", 64'(stall_ex), 64'(k != 0));
            @(posedge clk);
            mValid = 1'b0;
            flushed = 1'b1;
            break;
          end
          #1;
          checkOutput("stall_ex_busy", 64'(stall_ex), 64'(k != 0));
          @(posedge clk);
          if (k == 0) begin
            mTrd = x.trd; mRd = x.rd; mWr = x.wr; mLoad = 1'b0;
            pushExp(r, ovf);
          end
        end
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (flushed) begin
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      checkOutput("stall_ex_after_flush", 64'(stall_ex), 64'(0));
    end
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      randWb();
      @(posedge clk);
      mValid = 1'b0;
      @(negedge clk);
    end
  endtask

  function automatic logic [W-1:0] randOperand();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Held or reset edges do not produce a new EX/MEM entry.
  always @(posedge clk) heldEdge = hold || rst || flush;

  always @(negedge clk) begin
    exp_t e;
    if (!heldEdge && out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_out_valid", 64'(out_valid), 64'(0));
      end else begin
        e = sbq.pop_front();
        checkOutput("out_time", 64'($time) - 64'd5, 64'(e.t));
        checkOutput("out_fields", 64'({out_trd, out_rd, out_wr_en, out_load, out_ovf, out_data}),
                    64'({e.trd, e.rd, e.wr, e.load, e.ovf, e.data}));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d pending", sbq.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    instr_t x;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_out_data", 64'(out_data), 64'(0));
    checkOutput("reset_out_flags", 64'({out_wr_en, out_load, out_ovf, out_rd, out_trd}), 64'(0));
    checkOutput("reset_stall_ex", 64'(stall_ex), 64'(0));
    rst = 1'b0;

    $display("[TB] T1 MEM/WB forwarding");
    wb_trd = 3'd2; wb_rd = 5'd2; wb_data = 32'd9; wb_wr_en = 1'b1;
    applyStimulus(mk(3'd0, 2, 0, 0, 32'd5, 32'd0, 1, 1'b1, 1'b0), -1, -1);
    applyStimulus(mk(3'd0, 2, 1, 2, 32'd0, 32'd0, 3, 1'b1, 1'b0), -1, -1);
    checkOutput("t1_model_sum", 64'(mData), 64'd14);

    $display("[TB] T2 load-use bubble");
    wb_wr_en = 1'b0;
    applyStimulus(mk(3'd0, 1, 0, 0, 32'd100, 32'd0, 4, 1'b1, 1'b1), -1, -1);
    applyStimulus(mk(3'd1, 1, 4, 0, 32'd50, 32'd3, 5, 1'b1, 1'b0), -1, -1);
    applyStimulus(mk(3'd0, 1, 0, 0, 32'd200, 32'd0, 4, 1'b1, 1'b1), -1, -1);
    applyStimulus(mk(3'd0, 0, 4, 0, 32'd11, 32'd1, 6, 1'b1, 1'b0), -1, -1);

    $display("[TB] T3/T4 MUL and DIVU");
    applyStimulus(mk(3'd6, 3, 0, 0, 32'd7, 32'd6, 7, 1'b1, 1'b0), -1, -1);
    applyStimulus(mk(3'd6, 3, 0, 0, 32'h10000, 32'h10000, 7, 1'b1, 1'b0), -1, -1);
    applyStimulus(mk(3'd7, 4, 0, 0, 32'd100, 32'd7, 8, 1'b1, 1'b0), -1, -1);
    applyStimulus(mk(3'd7, 4, 0, 0, 32'd5, 32'd0, 8, 1'b1, 1'b0), -1, -1);

    $display("[TB] T5 flush mid-divide");
    applyStimulus(mk(3'd7, 5, 0, 0, 32'd999, 32'd4, 9, 1'b1, 1'b0), -1, 10);
    applyStimulus(mk(3'd0, 5, 0, 0, 32'd20, 32'd22, 9, 1'b1, 1'b0), -1, -1);

    $display("[TB] T6 hold mid-divide and ADD overflow");
    applyStimulus(mk(3'd7, 6, 0, 0, 32'd1000, 32'd3, 10, 1'b1, 1'b0), 15, -1);
    applyStimulus(mk(3'd0, 6, 0, 0, 32'h7FFF_FFFF, 32'd1, 10, 1'b1, 1'b0), -1, -1);
    idleCycles(2);

    $display("[TB] random phase");
    wbRandom = 1'b1;
    for (int i = 0; i < 300; i++) begin
      x = mk(3'($urandom_range(0, 7)), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 3), randOperand(), randOperand(), $urandom_range(0, 3),
             1'($urandom_range(0, 3) != 0), 1'b0);
      if (x.op < 3'd6) x.load = ($urandom_range(0, 3) == 0);
      applyStimulus(x, -1, -1);
      if ($urandom_range(0, 4) == 0) idleCycles(1);
    end
    idleCycles(3);
    checkOutput("scoreboard_drained", 64'(sbq.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
